// File: rtl/soml_pkg.sv
// Shared constants and saturation helper for the SOML decoder datapath.
// Default fixed-point format used by cmult, cdot_acc and the matrix/metric stages.
package soml_pkg;

    localparam int SOML_Q = 8;
    localparam int SOML_N = 16;

    // Reports whether a sign-extended wide value falls outside the n-bit signed range.
    // Callers sign-extend their accumulator to 64 bits, so any ACCW up to 64 is supported.
    function automatic logic sat_n_clip(input logic signed [63:0] x, input int n);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (n - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return (x > hi) || (x < lo);
    endfunction

endpackage

// File: rtl/cdot_acc.sv
// Complex dot-product accumulator sitting right after cmult.
// Sums LEN consecutive complex products, saturates each part to N bits and
// presents the result on a ready/valid output register.
module cdot_acc
    import soml_pkg::*;
#(
    parameter int Q    = SOML_Q,
    parameter int N    = SOML_N,
    parameter int LEN  = 4,
    localparam int ACCW = N + $clog2(LEN)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_r,
    input  logic [N-1:0] in_i,
    input  logic         in_clear,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_r,
    output logic [N-1:0] out_i,
    output logic         out_sat
);

    localparam int CNTW = $clog2(LEN);
    localparam logic [CNTW-1:0] LAST = CNTW'(LEN - 1);
    localparam logic [N-1:0] MAXV = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] MINV = {1'b1, {(N-1){1'b0}}};

    // Q is carried only for documentation of the format; the sum keeps cmult's scaling.
    if (LEN < 2 || Q >= N) begin : g_badParams
        $error("cdot_acc: LEN must be >= 2 and Q must be < N");
    end

    logic [CNTW-1:0]         r_cnt;
    logic signed [ACCW-1:0]  r_accR;
    logic signed [ACCW-1:0]  r_accI;
    logic                    r_outValid;
    logic [N-1:0]            r_outR;
    logic [N-1:0]            r_outI;
    logic                    r_outSat;

    logic                    w_accFire;
    logic                    w_outFire;
    logic                    w_isLast;
    logic                    w_load;
    logic signed [ACCW-1:0]  w_extR;
    logic signed [ACCW-1:0]  w_extI;
    logic signed [ACCW-1:0]  w_sumR;
    logic signed [ACCW-1:0]  w_sumI;
    logic                    w_clipR;
    logic                    w_clipI;
    logic [N-1:0]            w_satR;
    logic [N-1:0]            w_satI;

    // Handshake decode; only the final element of a frame is stalled by a held result,
    // and that stall deliberately looks straight through at out_ready.
    always_comb begin
        w_isLast  = (r_cnt == LAST);
        in_ready  = !(w_isLast && r_outValid && !out_ready);
        w_accFire = in_valid && in_ready;
        w_outFire = r_outValid && out_ready;
        w_load    = w_accFire && w_isLast && !in_clear;
    end

    // Sign-extend the incoming product, add it to the running sum and saturate to N bits.
    always_comb begin
        w_extR  = {{(ACCW-N){in_r[N-1]}}, in_r};
        w_extI  = {{(ACCW-N){in_i[N-1]}}, in_i};
        w_sumR  = r_accR + w_extR;
        w_sumI  = r_accI + w_extI;
        w_clipR = sat_n_clip(64'(w_sumR), N);
        w_clipI = sat_n_clip(64'(w_sumI), N);
        w_satR  = w_clipR ? (w_sumR[ACCW-1] ? MINV : MAXV) : w_sumR[N-1:0];
        w_satI  = w_clipI ? (w_sumI[ACCW-1] ? MINV : MAXV) : w_sumI[N-1:0];
    end

    // Element counter and accumulators; a clear wins over an accepted element and drops it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_accR <= '0;
            r_accI <= '0;
        end else if (in_clear) begin
            r_cnt  <= '0;
            r_accR <= '0;
            r_accI <= '0;
        end else if (w_accFire) begin
            if (r_cnt == '0) begin
                r_accR <= w_extR;
                r_accI <= w_extI;
                r_cnt  <= CNTW'(1);
            end else if (w_isLast) begin
                r_cnt  <= '0;
            end else begin
                r_accR <= w_sumR;
                r_accI <= w_sumI;
                r_cnt  <= r_cnt + CNTW'(1);
            end
        end
    end

    // Output register: a new result replaces a consumed one without a bubble,
    // otherwise data is held while valid stays up or after it is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outValid <= 1'b0;
            r_outR     <= '0;
            r_outI     <= '0;
            r_outSat   <= 1'b0;
        end else if (w_load) begin
            r_outValid <= 1'b1;
            r_outR     <= w_satR;
            r_outI     <= w_satI;
            r_outSat   <= w_clipR | w_clipI;
        end else if (w_outFire) begin
            r_outValid <= 1'b0;
        end
    end

    assign out_valid = r_outValid;
    assign out_r     = r_outR;
    assign out_i     = r_outI;
    assign out_sat   = r_outSat;

endmodule

// File: tb/tb_cdot_acc.sv
// Directed testbench for cdot_acc with hand-computed expected results.
module tb_cdot_acc;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_r;
    logic [15:0] in_i;
    logic        in_clear;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_r;
    logic [15:0] out_i;
    logic        out_sat;

    int testsRun;
    int testsFailed;

    int nomR[4] = '{-35, -387, 77, -264};
    int nomI[4] = '{193, 12, 60, 296};

    cdot_acc dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_r(in_r),
        .in_i(in_i),
        .in_clear(in_clear),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_r(out_r),
        .out_i(out_i),
        .out_sat(out_sat)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Present one element for a single cycle; returns 1 unit after the accepting edge.
    task automatic sendElem(input logic [15:0] r, input logic [15:0] i);
        in_valid = 1'b1;
        in_r     = r;
        in_i     = i;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Send the four nominal products back-to-back, with optional idle cycles between them.
    task automatic sendNominal(input int gap);
        for (int k = 0; k < 4; k++) begin
            sendElem(16'(nomR[k]), 16'(nomI[k]));
            if (k < 3) repeat (gap) @(posedge clk);
            if (k < 3 && gap > 0) #1;
        end
    endtask

    // Check the nominal result (-609, 561) is on the output.
    task automatic checkNominal(input string tag);
        testsRun++;
        if (out_valid !== 1'b1 || out_r !== 16'hFD9F || out_i !== 16'h0231 || out_sat !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL %s: got v=%b r=%h i=%h sat=%b, want v=1 r=fd9f i=0231 sat=0",
                     tag, out_valid, out_r, out_i, out_sat);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        testsRun++;
        if (out_valid !== 1'b0 || out_r !== 16'h0 || out_i !== 16'h0 || out_sat !== 1'b0 || in_ready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL reset: got v=%b r=%h i=%h sat=%b rdy=%b, want 0 0 0 0 1",
                     out_valid, out_r, out_i, out_sat, in_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_nominal();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sendElem(16'(nomR[k]), 16'(nomI[k]));
            if (k == 2) begin
                testsRun++;
                if (out_valid !== 1'b0) begin
                    testsFailed++;
                    $display("[TB] FAIL nominal early valid: got %b want 0", out_valid);
                end
            end
        end
        checkNominal("nominal");
        @(posedge clk);
        #1;
        testsRun++;
        if (out_valid !== 1'b0 || out_r !== 16'hFD9F) begin
            testsFailed++;
            $display("[TB] FAIL nominal consume: got v=%b r=%h want v=0 r=fd9f", out_valid, out_r);
        end
    endtask

    task automatic test_saturation();
        out_ready = 1'b1;
        repeat (4) sendElem(16'h7000, 16'h0000);
        testsRun++;
        if (out_valid !== 1'b1 || out_r !== 16'h7FFF || out_i !== 16'h0000 || out_sat !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL sat_pos: got v=%b r=%h i=%h sat=%b want 1 7fff 0000 1",
                     out_valid, out_r, out_i, out_sat);
        end
        repeat (4) sendElem(16'h8000, 16'h8000);
        testsRun++;
        if (out_valid !== 1'b1 || out_r !== 16'h8000 || out_i !== 16'h8000 || out_sat !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL sat_neg: got v=%b r=%h i=%h sat=%b want 1 8000 8000 1",
                     out_valid, out_r, out_i, out_sat);
        end
        // Sums land exactly on the range limits and must not be flagged.
        sendElem(16'h7FFF, 16'h8000);
        sendElem(16'h0001, 16'h0000);
        sendElem(16'hFFFF, 16'h0000);
        sendElem(16'h0000, 16'h0000);
        testsRun++;
        if (out_valid !== 1'b1 || out_r !== 16'h7FFF || out_i !== 16'h8000 || out_sat !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL sat_edge: got v=%b r=%h i=%h sat=%b want 1 7fff 8000 0",
                     out_valid, out_r, out_i, out_sat);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        sendNominal(0);
        checkNominal("bp frame A");
        // Frame B = (1,2),(3,4),(5,6),(7,8) -> (16, 20)
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_r     = 16'(2 * k + 1);
            in_i     = 16'(2 * k + 2);
            #1;
            testsRun++;
            if (in_ready !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL bp early ready elem %0d: got %b want 1", k, in_ready);
            end
            @(posedge clk);
            #1;
        end
        in_r = 16'd7;
        in_i = 16'd8;
        #1;
        testsRun++;
        if (in_ready !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL bp stall: got in_ready=%b want 0", in_ready);
        end
        repeat (2) begin
            @(posedge clk);
            #1;
            checkNominal("bp hold A");
        end
        out_ready = 1'b1;
        #1;
        testsRun++;
        if (in_ready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL bp release ready: got %b want 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        testsRun++;
        if (out_valid !== 1'b1 || out_r !== 16'h0010 || out_i !== 16'h0014 || out_sat !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL bp frame B: got v=%b r=%h i=%h sat=%b want 1 0010 0014 0",
                     out_valid, out_r, out_i, out_sat);
        end
        @(posedge clk);
        #1;
        testsRun++;
        if (out_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL bp consume B: got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_gaps();
        out_ready = 1'b1;
        sendElem(16'(nomR[0]), 16'(nomI[0]));
        repeat (3) @(posedge clk);
        #1;
        testsRun++;
        if (out_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL gaps idle valid: got %b want 0", out_valid);
        end
        for (int k = 1; k < 4; k++) begin
            sendElem(16'(nomR[k]), 16'(nomI[k]));
            if (k < 3) begin
                repeat (2) @(posedge clk);
                #1;
            end
        end
        checkNominal("gaps");
        @(posedge clk);
        #1;
    endtask

    task automatic test_clear();
        out_ready = 1'b1;
        sendElem(16'd100, 16'd100);
        sendElem(16'd200, 16'd200);
        in_valid = 1'b1;
        in_clear = 1'b1;
        in_r     = 16'd999;
        in_i     = 16'd999;
        @(posedge clk);
        #1;
        in_clear = 1'b0;
        in_valid = 1'b0;
        testsRun++;
        if (out_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL clear valid: got %b want 0", out_valid);
        end
        sendNominal(0);
        checkNominal("clear");
        @(posedge clk);
        #1;
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        sendNominal(0);
        checkNominal("rst pending");
        sendElem(16'd50, 16'd50);
        sendElem(16'd60, 16'd60);
        #2;
        rst_n = 1'b0;
        #1;
        testsRun++;
        if (out_valid !== 1'b0 || out_r !== 16'h0 || out_i !== 16'h0 || out_sat !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL async reset: got v=%b r=%h i=%h sat=%b want all 0",
                     out_valid, out_r, out_i, out_sat);
        end
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        sendNominal(0);
        checkNominal("after reset");
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst_n       = 1'b1;
        in_valid    = 1'b0;
        in_r        = '0;
        in_i        = '0;
        in_clear    = 1'b0;
        out_ready   = 1'b1;
        #1;
        test_reset();
        test_nominal();
        test_saturation();
        test_back_to_back();
        test_gaps();
        test_clear();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
